// File: rtl/core_ex_issue_stage.sv
// Execute issue stage: two-entry skid buffer between decode and the shift unit,
// with MEM/WB operand bypass applied at the output and captured into held entries.
package core_pkg;
  localparam int DATA_WIDTH = 32;
endpackage

package shift_control_pkg;
  localparam int SHIFT_WIDTH_CODE = 2;
  localparam logic [SHIFT_WIDTH_CODE-1:0] SHIFT_NONE = 2'd0;
  localparam logic [SHIFT_WIDTH_CODE-1:0] SHIFT_SLL  = 2'd1;
  localparam logic [SHIFT_WIDTH_CODE-1:0] SHIFT_SRL  = 2'd2;
  localparam logic [SHIFT_WIDTH_CODE-1:0] SHIFT_SRA  = 2'd3;
endpackage

module core_ex_issue_stage #(
  parameter int DATA_WIDTH       = core_pkg::DATA_WIDTH,
  parameter int SHIFT_WIDTH_CODE = shift_control_pkg::SHIFT_WIDTH_CODE,
  parameter int REG_ADDR_WIDTH   = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        id_valid,
  output logic                        id_ready,
  input  logic [SHIFT_WIDTH_CODE-1:0] id_shift_control,
  input  logic [REG_ADDR_WIDTH-1:0]   id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0]   id_rs2,
  input  logic [DATA_WIDTH-1:0]       id_op_a,
  input  logic [DATA_WIDTH-1:0]       id_op_b,
  input  logic [REG_ADDR_WIDTH-1:0]   id_rd,
  input  logic                        mem_fwd_en,
  input  logic [REG_ADDR_WIDTH-1:0]   mem_fwd_rd,
  input  logic [DATA_WIDTH-1:0]       mem_fwd_data,
  input  logic                        wb_fwd_en,
  input  logic [REG_ADDR_WIDTH-1:0]   wb_fwd_rd,
  input  logic [DATA_WIDTH-1:0]       wb_fwd_data,
  input  logic                        flush,
  output logic                        ex_valid,
  input  logic                        ex_ready,
  output logic [SHIFT_WIDTH_CODE-1:0] ex_shift_control,
  output logic [DATA_WIDTH-1:0]       ex_in_a,
  output logic [DATA_WIDTH-1:0]       ex_in_b,
  output logic [REG_ADDR_WIDTH-1:0]   ex_rd
);

  typedef struct packed {
    logic [SHIFT_WIDTH_CODE-1:0] shift;
    logic [REG_ADDR_WIDTH-1:0]   rs1;
    logic [REG_ADDR_WIDTH-1:0]   rs2;
    logic [DATA_WIDTH-1:0]       op_a;
    logic [DATA_WIDTH-1:0]       op_b;
    logic [REG_ADDR_WIDTH-1:0]   rd;
  } entry_t;

  localparam entry_t ENTRY_RESET = '{
    shift: SHIFT_WIDTH_CODE'(shift_control_pkg::SHIFT_NONE),
    rs1: '0, rs2: '0, op_a: '0, op_b: '0, rd: '0
  };

  entry_t main_q, main_d, skid_q, skid_d, in_e, main_fw, skid_fw;
  logic   main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic   xfer_in, xfer_out;

  // Register zero is hardwired, so it never takes bypass data.
  function automatic logic [DATA_WIDTH-1:0] fwd(
    input logic [REG_ADDR_WIDTH-1:0] rs,
    input logic [DATA_WIDTH-1:0]     stored,
    input logic                      m_en,
    input logic [REG_ADDR_WIDTH-1:0] m_rd,
    input logic [DATA_WIDTH-1:0]     m_data,
    input logic                      w_en,
    input logic [REG_ADDR_WIDTH-1:0] w_rd,
    input logic [DATA_WIDTH-1:0]     w_data
  );
    if (rs == '0)                  return stored;
    else if (m_en && m_rd == rs)   return m_data;
    else if (w_en && w_rd == rs)   return w_data;
    else                           return stored;
  endfunction

  always_comb begin
    main_fw      = main_q;
    main_fw.op_a = fwd(main_q.rs1, main_q.op_a, mem_fwd_en, mem_fwd_rd, mem_fwd_data,
                       wb_fwd_en, wb_fwd_rd, wb_fwd_data);
    main_fw.op_b = fwd(main_q.rs2, main_q.op_b, mem_fwd_en, mem_fwd_rd, mem_fwd_data,
                       wb_fwd_en, wb_fwd_rd, wb_fwd_data);
    skid_fw      = skid_q;
    skid_fw.op_a = fwd(skid_q.rs1, skid_q.op_a, mem_fwd_en, mem_fwd_rd, mem_fwd_data,
                       wb_fwd_en, wb_fwd_rd, wb_fwd_data);
    skid_fw.op_b = fwd(skid_q.rs2, skid_q.op_b, mem_fwd_en, mem_fwd_rd, mem_fwd_data,
                       wb_fwd_en, wb_fwd_rd, wb_fwd_data);
  end

  assign in_e = '{shift: id_shift_control, rs1: id_rs1, rs2: id_rs2,
                  op_a: id_op_a, op_b: id_op_b, rd: id_rd};

  // id_ready depends only on registered skid state, never on ex_ready.
  assign id_ready = ~skid_valid_q;
  assign xfer_in  = id_valid & id_ready;
  assign xfer_out = main_valid_q & ex_ready;

  always_comb begin
    // Held entries absorb bypass data every cycle so it survives MEM/WB retiring.
    main_d       = main_fw;
    skid_d       = skid_fw;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (xfer_out) begin
      if (skid_valid_q) begin
        main_d       = skid_fw;
        skid_valid_d = 1'b0;
      end else if (xfer_in) begin
        main_d = in_e;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (main_valid_q) begin
      if (xfer_in) begin
        skid_d       = in_e;
        skid_valid_d = 1'b1;
      end
    end else if (xfer_in) begin
      main_d       = in_e;
      main_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q       <= ENTRY_RESET;
      skid_q       <= ENTRY_RESET;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign ex_valid         = main_valid_q;
  assign ex_shift_control = main_q.shift;
  assign ex_in_a          = main_fw.op_a;
  assign ex_in_b          = main_fw.op_b;
  assign ex_rd            = main_q.rd;

endmodule

// File: tb/tb_core_ex_issue_stage.sv
// Bench for core_ex_issue_stage: directed scenarios plus random traffic, all
// checked against a queue-based model of the two-deep issue buffer.
module tb_core_ex_issue_stage;
  localparam int DW = 32;
  localparam int SW = 2;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, id_ready;
  logic [SW-1:0] id_shift_control;
  logic [RW-1:0] id_rs1, id_rs2, id_rd;
  logic [DW-1:0] id_op_a, id_op_b;
  logic          mem_fwd_en, wb_fwd_en;
  logic [RW-1:0] mem_fwd_rd, wb_fwd_rd;
  logic [DW-1:0] mem_fwd_data, wb_fwd_data;
  logic          flush;
  logic          ex_valid, ex_ready;
  logic [SW-1:0] ex_shift_control;
  logic [DW-1:0] ex_in_a, ex_in_b;
  logic [RW-1:0] ex_rd;

  core_ex_issue_stage #(.DATA_WIDTH(DW), .SHIFT_WIDTH_CODE(SW), .REG_ADDR_WIDTH(RW)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ready(id_ready), .id_shift_control(id_shift_control),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_op_a(id_op_a), .id_op_b(id_op_b), .id_rd(id_rd),
    .mem_fwd_en(mem_fwd_en), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_en(wb_fwd_en), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
    .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_shift_control(ex_shift_control), .ex_in_a(ex_in_a), .ex_in_b(ex_in_b), .ex_rd(ex_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SW-1:0] shift;
    logic [RW-1:0] rs1, rs2, rd;
    logic [DW-1:0] a, b;
  } instr_t;

  instr_t q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] bypass(input logic [RW-1:0] rs, input logic [DW-1:0] v);
    if (rs == 0) return v;
    if (mem_fwd_en && mem_fwd_rd == rs) return mem_fwd_data;
    if (wb_fwd_en && wb_fwd_rd == rs) return wb_fwd_data;
    return v;
  endfunction

  // Compare outputs with the queue model, then advance the model by one clock.
  task automatic model_cycle();
    bit rdy, out;
    instr_t e;
    rdy = (q.size() < 2);
    out = (q.size() > 0) && ex_ready;
    check("id_ready", 32'(id_ready), 32'(rdy));
    check("ex_valid", 32'(ex_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      check("ex_shift", 32'(ex_shift_control), 32'(q[0].shift));
      check("ex_rd", 32'(ex_rd), 32'(q[0].rd));
      check("ex_in_a", ex_in_a, bypass(q[0].rs1, q[0].a));
      check("ex_in_b", ex_in_b, bypass(q[0].rs2, q[0].b));
    end
    if (flush) q.delete();
    else begin
      if (out) void'(q.pop_front());
      foreach (q[i]) begin
        q[i].a = bypass(q[i].rs1, q[i].a);
        q[i].b = bypass(q[i].rs2, q[i].b);
      end
      if (id_valid && rdy) begin
        e.shift = id_shift_control; e.rs1 = id_rs1; e.rs2 = id_rs2;
        e.rd = id_rd; e.a = id_op_a; e.b = id_op_b;
        q.push_back(e);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_shift_control = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_op_a = 0; id_op_b = 0; mem_fwd_en = 0; mem_fwd_rd = 0; mem_fwd_data = 0;
    wb_fwd_en = 0; wb_fwd_rd = 0; wb_fwd_data = 0; flush = 0; ex_ready = 0;
  endtask

  task automatic offer(input logic [SW-1:0] sh, input logic [RW-1:0] r1, input logic [RW-1:0] r2,
                       input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [RW-1:0] rd);
    id_valid = 1; id_shift_control = sh; id_rs1 = r1; id_rs2 = r2;
    id_op_a = a; id_op_b = b; id_rd = rd;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ex_valid"}, 32'(ex_valid), 0);
    check({tag, "_id_ready"}, 32'(id_ready), 1);
    check({tag, "_shift"}, 32'(ex_shift_control), 32'(shift_control_pkg::SHIFT_NONE));
    check({tag, "_in_a"}, ex_in_a, 0);
    check({tag, "_in_b"}, ex_in_b, 0);
    check({tag, "_rd"}, 32'(ex_rd), 0);
  endtask

  task automatic drain();
    idle_inputs();
    flush = 1;
    step();
    flush = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 0;
    q.delete();

    // Single instruction: one cycle latency, gone the cycle after.
    ex_ready = 1;
    offer(shift_control_pkg::SHIFT_SLL, 0, 0, 32'h1, 32'h4, 3);
    step();
    id_valid = 0;
    check("sll_valid", 32'(ex_valid), 1);
    check("sll_a", ex_in_a, 32'h1);
    check("sll_b", ex_in_b, 32'h4);
    step();
    check("sll_gone", 32'(ex_valid), 0);

    // Three back-to-back offers into a stalled stage.
    ex_ready = 0;
    offer(1, 0, 0, 32'h11, 32'h12, 1); step();
    offer(2, 0, 0, 32'h21, 32'h22, 2); step();
    check("stall_full_ready", 32'(id_ready), 0);
    offer(3, 0, 0, 32'h31, 32'h32, 3); step();
    check("stall_third_ready", 32'(id_ready), 0);
    id_valid = 0; ex_ready = 1;
    check("order_1", 32'(ex_rd), 1); step();
    check("order_2", 32'(ex_rd), 2); step();
    check("third_never_taken", 32'(ex_valid), 0);
    offer(3, 0, 0, 32'h31, 32'h32, 3); step();
    id_valid = 0;
    check("order_3", 32'(ex_rd), 3); step();
    check("order_empty", 32'(ex_valid), 0);

    // MEM wins over WB, and the bypass value is kept after MEM retires.
    ex_ready = 0;
    offer(1, 5, 0, 32'hAAAA, 32'h7, 7); step();
    id_valid = 0;
    mem_fwd_en = 1; mem_fwd_rd = 5; mem_fwd_data = 32'h1234;
    wb_fwd_en = 1;  wb_fwd_rd = 5;  wb_fwd_data = 32'h5678;
    #1 check("fwd_mem_prio", ex_in_a, 32'h1234);
    step();
    mem_fwd_en = 0; wb_fwd_en = 0;
    #1 check("fwd_captured", ex_in_a, 32'h1234);
    step();
    check("fwd_still", ex_in_a, 32'h1234);
    drain();

    // Register zero never forwards.
    offer(2, 0, 0, 32'h1, 32'hBEEF, 4); step();
    id_valid = 0;
    mem_fwd_en = 1; mem_fwd_rd = 0; mem_fwd_data = 32'hFFFF_FFFF;
    #1 check("x0_no_fwd", ex_in_b, 32'hBEEF);
    step();
    check("x0_no_capture", ex_in_b, 32'hBEEF);
    mem_fwd_en = 0;
    drain();

    // Flush with both entries full and a simultaneous offer.
    offer(1, 0, 0, 32'h1, 32'h1, 8); step();
    offer(1, 0, 0, 32'h2, 32'h2, 9); step();
    check("both_full_ready", 32'(id_ready), 0);
    offer(1, 0, 0, 32'h3, 32'h3, 10);
    flush = 1; step();
    flush = 0; id_valid = 0; ex_ready = 1;
    check("flush_valid", 32'(ex_valid), 0);
    check("flush_ready", 32'(id_ready), 1);
    step();
    check("flush_nothing_emitted", 32'(ex_valid), 0);

    // Asynchronous reset in the middle of a stall.
    ex_ready = 0;
    offer(shift_control_pkg::SHIFT_SRA, 6, 7, 32'hC0DE, 32'hF00D, 11); step();
    id_valid = 0;
    check("pre_rst_valid", 32'(ex_valid), 1);
    #2 rst = 1;
    #1 check_reset_outputs("async_rst");
    q.delete();
    @(posedge clk); #1 rst = 0;
    ex_ready = 1;
    step();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      id_valid         = ($urandom_range(0, 3) != 0);
      id_shift_control = SW'($urandom);
      id_rs1           = RW'($urandom_range(0, 3));
      id_rs2           = RW'($urandom_range(0, 3));
      id_rd            = RW'($urandom);
      id_op_a          = $urandom;
      id_op_b          = $urandom;
      mem_fwd_en       = ($urandom_range(0, 2) == 0);
      mem_fwd_rd       = RW'($urandom_range(0, 3));
      mem_fwd_data     = $urandom;
      wb_fwd_en        = ($urandom_range(0, 2) == 0);
      wb_fwd_rd        = RW'($urandom_range(0, 3));
      wb_fwd_data      = $urandom;
      ex_ready         = ($urandom_range(0, 2) != 0);
      flush            = ($urandom_range(0, 40) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/core_ex_issue_stage.md
CORE_EX_ISSUE_STAGE -- requirements
Module: core_ex_issue_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default from core_pkg (32), meaning operand and result width.
REQ-002 SHALL have parameter SHIFT_WIDTH_CODE, default from shift_control_pkg, meaning shift control code width.
REQ-003 SHALL have parameter REG_ADDR_WIDTH, default 5, meaning register index width.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning reset: asynchronous, active-high.
REQ-006 SHALL have port id_valid, input, 1, meaning decode offers an instruction.
REQ-007 SHALL have port id_ready, output, 1, meaning the stage accepts this cycle.
REQ-008 SHALL have port id_shift_control, input, SHIFT_WIDTH_CODE, meaning the shift operation code.
REQ-009 SHALL have ports id_rs1 and id_rs2, input, REG_ADDR_WIDTH each, meaning source indices.
REQ-010 SHALL have ports id_op_a and id_op_b, input, DATA_WIDTH each, meaning register-file read data.
REQ-011 SHALL have port id_rd, input, REG_ADDR_WIDTH, meaning destination index.
REQ-012 SHALL have ports mem_fwd_en, mem_fwd_rd, mem_fwd_data, inputs, 1/REG_ADDR_WIDTH/DATA_WIDTH, meaning MEM-stage bypass.
REQ-013 SHALL have ports wb_fwd_en, wb_fwd_rd, wb_fwd_data, inputs, 1/REG_ADDR_WIDTH/DATA_WIDTH, meaning WB-stage bypass.
REQ-014 SHALL have port flush, input, 1, meaning discard all held instructions.
REQ-015 SHALL have port ex_valid, output, 1, meaning execute operands are valid.
REQ-016 SHALL have port ex_ready, input, 1, meaning execute consumes this cycle.
REQ-017 SHALL have ports ex_shift_control (SHIFT_WIDTH_CODE), ex_in_a, ex_in_b (DATA_WIDTH), ex_rd (REG_ADDR_WIDTH), outputs, meaning operands to the shift unit.

Function
REQ-018 SHALL hold two entries: a main register, which drives ex_*, and a skid register. Each entry stores shift_control, rs1, rs2, op_a, op_b, rd and a valid bit.
REQ-019 SHALL drive id_ready = NOT skid_valid, registered, so that id_ready has no combinational path from ex_ready.
REQ-020 SHALL define transfer-in as id_valid AND id_ready, and transfer-out as ex_valid AND ex_ready.
REQ-021 SHALL drive ex_valid = main_valid.
REQ-022 SHALL load a transfer-in into the main register when main is empty, or when main is emptying this cycle and skid is empty.
REQ-023 SHALL load a transfer-in into the skid register when main is full and not emptying.
REQ-024 SHALL, on transfer-out with skid valid, move skid to main and clear skid_valid.
REQ-025 SHALL keep ordering strict FIFO; no instruction is dropped or duplicated.
REQ-026 SHALL produce latency of 1 cycle from transfer-in to ex_valid when the stage is empty.
REQ-027 SHALL sustain full throughput of one instruction per cycle when ex_ready is held at 1.
REQ-028 SHALL form ex_in_a from the main entry op_a with forwarding applied combinationally at the output, using the held rs1.
REQ-029 SHALL form ex_in_b the same way, using the held rs2.
REQ-030 SHALL apply forwarding priority MEM over WB over stored value; the MEM source matches when mem_fwd_en=1 and mem_fwd_rd==rs.
REQ-031 SHALL never forward to index 0; rs==0 always yields the stored value.
REQ-032 SHALL update stored op_a and op_b in place with the forwarded value each cycle the main entry is held and a match exists, so bypass data is not lost after it leaves MEM or WB.
REQ-033 SHALL apply the REQ-032 capture to the skid entry as well.
REQ-034 SHALL, on flush, clear both valid bits on the next edge and drop any simultaneous transfer-in; id_ready is 1 the following cycle.
REQ-035 SHALL give flush priority over every other event in the same cycle.
REQ-036 SHALL hold ex_* data stable while ex_valid=1 and ex_ready=0, except for forwarding updates per REQ-032.
REQ-037 SHALL accept any ex_* data value while ex_valid=0 (don't-care).

Reset
REQ-038 SHALL, while rst=1, force main_valid=0, skid_valid=0, ex_valid=0, id_ready=1, ex_shift_control=shift_none, ex_in_a=0, ex_in_b=0, ex_rd=0, and all stored fields=0.
REQ-039 SHALL abort any in-flight entries when reset is asserted mid-operation; no transfer-out occurs in the first cycle after rst deasserts.

Verification
REQ-040 SHALL pass this scenario: reset, then a single instruction with shift_control=shift_sll, op_a=0x1, op_b=0x4, ex_ready=1 -> ex_valid=1 one cycle later with ex_in_a=0x1 and ex_in_b=0x4; ex_valid=0 the next cycle.
REQ-041 SHALL pass this scenario: ex_ready=0 with three back-to-back id_valid offers -> the first two are accepted and id_ready=0 on the third. Then ex_ready=1 -> outputs appear in order 1, 2, 3 with no loss.
REQ-042 SHALL pass this scenario: held instruction with rs1=5, op_a=0xAAAA, mem_fwd_en=1, mem_fwd_rd=5, mem_fwd_data=0x1234, and WB also matching 0x5678 -> ex_in_a=0x1234. After the MEM match drops, ex_in_a stays 0x1234.
REQ-043 SHALL pass this scenario: rs2=0 with mem_fwd_rd=0, mem_fwd_en=1, data 0xFFFF_FFFF -> ex_in_b equals the stored op_b.
REQ-044 SHALL pass this scenario: both entries full, then flush=1 together with id_valid=1 -> next cycle ex_valid=0 and id_ready=1, with no instruction emitted.
REQ-045 SHALL pass this scenario: rst asserted asynchronously mid-stall -> ex_valid falls immediately and ex_shift_control=shift_none.
